// File: rtl/mem_stage_ctrl.sv
// mem_stage_ctrl: data-memory request/hit handshake and memory/write-back latch.
module mem_stage_ctrl #(
    parameter int WORD_W = 32,
    parameter int REG_AW = 5
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              mem_en,
    input  logic              flush,
    input  logic [WORD_W-1:0] outputi,
    input  logic [WORD_W-1:0] wdati,
    input  logic              dRENi,
    input  logic              dWENi,
    input  logic              reg_wri,
    input  logic [REG_AW-1:0] wseli,
    input  logic              write_sigi,
    input  logic              halti,
    input  logic              dhit,
    input  logic [WORD_W-1:0] dmemload,
    output logic              dmemREN,
    output logic              dmemWEN,
    output logic [WORD_W-1:0] dmemaddr,
    output logic [WORD_W-1:0] dmemstore,
    output logic              mem_stall,
    output logic [WORD_W-1:0] wb_result,
    output logic [WORD_W-1:0] wb_load,
    output logic [REG_AW-1:0] wb_wsel,
    output logic              wb_reg_wr,
    output logic              wb_write_sig,
    output logic              wb_halt
);
    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] ACCESS = 2'd1;
    localparam logic [1:0] HALTED = 2'd2;

    logic [1:0] r_state;
    logic       r_flush_pend;
    logic       r_halt_pend;
    logic       w_op;
    logic       w_squash;
    logic       w_halt_done;

    always_comb begin
        w_op        = dRENi | dWENi;
        w_squash    = flush | r_flush_pend;
        w_halt_done = r_halt_pend & ~w_squash;
        mem_stall   = RST ? 1'b0 :
                      (r_state == IDLE)   ? (w_op & ~flush) :
                      (r_state == ACCESS) ? ~dhit : 1'b0;
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_state      <= IDLE;
            r_flush_pend <= 1'b0;
            r_halt_pend  <= 1'b0;
            dmemREN      <= 1'b0;
            dmemWEN      <= 1'b0;
            dmemaddr     <= '0;
            dmemstore    <= '0;
            wb_result    <= '0;
            wb_load      <= '0;
            wb_wsel      <= '0;
            wb_reg_wr    <= 1'b0;
            wb_write_sig <= 1'b0;
            wb_halt      <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (flush) begin
                        wb_reg_wr    <= 1'b0;
                        wb_wsel      <= '0;
                        wb_write_sig <= 1'b0;
                    end else if (w_op) begin
                        dmemaddr    <= outputi;
                        dmemstore   <= wdati;
                        dmemWEN     <= dWENi;
                        dmemREN     <= dRENi & ~dWENi;
                        r_halt_pend <= halti;
                        r_state     <= ACCESS;
                    end else begin
                        if (mem_en) begin
                            wb_result    <= outputi;
                            wb_load      <= '0;
                            wb_wsel      <= wseli;
                            wb_reg_wr    <= reg_wri;
                            wb_write_sig <= write_sigi;
                        end
                        if (halti) begin
                            r_state   <= HALTED;
                            wb_halt   <= 1'b1;
                            wb_reg_wr <= 1'b0;
                        end
                    end
                end
                ACCESS: begin
                    if (dhit) begin
                        dmemREN      <= 1'b0;
                        dmemWEN      <= 1'b0;
                        wb_result    <= dmemaddr;
                        wb_load      <= dmemREN ? dmemload : '0;
                        wb_wsel      <= w_squash ? '0 : wseli;
                        wb_reg_wr    <= ~w_squash & reg_wri;
                        wb_write_sig <= ~w_squash & write_sigi;
                        r_flush_pend <= 1'b0;
                        r_halt_pend  <= 1'b0;
                        r_state      <= w_halt_done ? HALTED : IDLE;
                        wb_halt      <= w_halt_done;
                    end else if (flush) begin
                        r_flush_pend <= 1'b1;
                    end
                end
                HALTED: begin
                    wb_reg_wr <= 1'b0;
                    wb_halt   <= 1'b1;
                end
                default: r_state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_mem_stage_ctrl.sv
// tb_mem_stage_ctrl: directed scenario tests for mem_stage_ctrl.
module tb_mem_stage_ctrl;
    logic        CLK = 1'b0;
    logic        RST, mem_en, flush, dRENi, dWENi, reg_wri, write_sigi, halti, dhit;
    logic [31:0] outputi, wdati, dmemload;
    logic [4:0]  wseli;
    logic        dmemREN, dmemWEN, mem_stall, wb_reg_wr, wb_write_sig, wb_halt;
    logic [31:0] dmemaddr, dmemstore, wb_result, wb_load;
    logic [4:0]  wb_wsel;
    int n_cmp = 0;
    int n_err = 0;

    mem_stage_ctrl dut (
        .CLK(CLK), .RST(RST), .mem_en(mem_en), .flush(flush), .outputi(outputi),
        .wdati(wdati), .dRENi(dRENi), .dWENi(dWENi), .reg_wri(reg_wri), .wseli(wseli),
        .write_sigi(write_sigi), .halti(halti), .dhit(dhit), .dmemload(dmemload),
        .dmemREN(dmemREN), .dmemWEN(dmemWEN), .dmemaddr(dmemaddr), .dmemstore(dmemstore),
        .mem_stall(mem_stall), .wb_result(wb_result), .wb_load(wb_load), .wb_wsel(wb_wsel),
        .wb_reg_wr(wb_reg_wr), .wb_write_sig(wb_write_sig), .wb_halt(wb_halt)
    );

    always #5 CLK = ~CLK;

    task automatic cyc();
        @(negedge CLK);
    endtask

    task automatic idle_inputs();
        mem_en = 1'b1; flush = 1'b0; dRENi = 1'b0; dWENi = 1'b0; reg_wri = 1'b0;
        write_sigi = 1'b0; halti = 1'b0; dhit = 1'b0; outputi = '0; wdati = '0;
        dmemload = '0; wseli = '0;
    endtask

    task automatic test_reset();
        idle_inputs();
        RST = 1'b1; dRENi = 1'b1; outputi = 32'h100;
        cyc(); cyc();
        n_cmp++; if (mem_stall !== 1'b0) begin n_err++; $display("FAIL rst_stall got %b exp 0", mem_stall); end
        n_cmp++; if ({dmemREN, dmemWEN, dmemaddr, wb_result, wb_wsel, wb_reg_wr, wb_halt} !== '0) begin
            n_err++; $display("FAIL rst_outputs got REN=%b WEN=%b addr=%h res=%h halt=%b exp all 0",
                              dmemREN, dmemWEN, dmemaddr, wb_result, wb_halt); end
        RST = 1'b0;
        cyc();
        n_cmp++; if (dmemREN !== 1'b1 || dmemaddr !== 32'h100) begin n_err++;
            $display("FAIL rst_release_req got REN=%b addr=%h exp 1 100", dmemREN, dmemaddr); end
        dhit = 1'b1;
        cyc();
        idle_inputs();
    endtask

    task automatic test_load();
        int stalls = 0;
        dRENi = 1'b1; outputi = 32'h200; reg_wri = 1'b1; wseli = 5'd5; write_sigi = 1'b1;
        for (int i = 0; i < 4; i++) begin
            #1 if (mem_stall) stalls++;
            cyc();
        end
        dhit = 1'b1; dmemload = 32'hDEADBEEF;
        #1 if (mem_stall) stalls++;
        n_cmp++; if (stalls !== 4) begin n_err++; $display("FAIL load_stall_cycles got %0d exp 4", stalls); end
        cyc();
        n_cmp++; if (wb_load !== 32'hDEADBEEF || wb_result !== 32'h200) begin n_err++;
            $display("FAIL load_data got load=%h res=%h exp deadbeef 200", wb_load, wb_result); end
        n_cmp++; if (wb_wsel !== 5'd5 || wb_reg_wr !== 1'b1 || wb_write_sig !== 1'b1 || dmemREN !== 1'b0) begin
            n_err++; $display("FAIL load_ctrl got wsel=%0d wr=%b ws=%b REN=%b exp 5 1 1 0",
                              wb_wsel, wb_reg_wr, wb_write_sig, dmemREN); end
        idle_inputs();
    endtask

    task automatic test_store_load();
        dRENi = 1'b1; dWENi = 1'b1; wdati = 32'h1234; outputi = 32'h40;
        cyc();
        n_cmp++; if (dmemWEN !== 1'b1 || dmemREN !== 1'b0 || dmemstore !== 32'h1234 || dmemaddr !== 32'h40) begin
            n_err++; $display("FAIL store_req got WEN=%b REN=%b st=%h addr=%h exp 1 0 1234 40",
                              dmemWEN, dmemREN, dmemstore, dmemaddr); end
        dhit = 1'b1; dmemload = 32'hFFFF;
        cyc();
        n_cmp++; if (wb_load !== 32'h0 || wb_result !== 32'h40 || dmemWEN !== 1'b0) begin n_err++;
            $display("FAIL store_done got load=%h res=%h WEN=%b exp 0 40 0", wb_load, wb_result, dmemWEN); end
        idle_inputs();
    endtask

    task automatic test_flush_access();
        dRENi = 1'b1; outputi = 32'h300; reg_wri = 1'b1; wseli = 5'd9; write_sigi = 1'b1;
        cyc(); cyc();
        flush = 1'b1;
        cyc();
        flush = 1'b0;
        #1;
        n_cmp++; if (dmemREN !== 1'b1 || dmemaddr !== 32'h300 || mem_stall !== 1'b1) begin n_err++;
            $display("FAIL flush_hold got REN=%b addr=%h stall=%b exp 1 300 1", dmemREN, dmemaddr, mem_stall); end
        dhit = 1'b1; dmemload = 32'h55;
        cyc();
        n_cmp++; if (wb_reg_wr !== 1'b0 || wb_wsel !== 5'd0 || dmemREN !== 1'b0) begin n_err++;
            $display("FAIL flush_bubble got wr=%b wsel=%0d REN=%b exp 0 0 0", wb_reg_wr, wb_wsel, dmemREN); end
        dhit = 1'b0; outputi = 32'h304; wseli = 5'd3;
        cyc();
        dhit = 1'b1;
        cyc();
        n_cmp++; if (wb_reg_wr !== 1'b1 || wb_wsel !== 5'd3) begin n_err++;
            $display("FAIL flush_pend_clear got wr=%b wsel=%0d exp 1 3", wb_reg_wr, wb_wsel); end
        idle_inputs();
    endtask

    task automatic test_alu();
        outputi = 32'd7; reg_wri = 1'b1; wseli = 5'd2;
        #1;
        n_cmp++; if (mem_stall !== 1'b0) begin n_err++; $display("FAIL alu_stall got %b exp 0", mem_stall); end
        cyc();
        n_cmp++; if (wb_result !== 32'd7 || wb_load !== 32'd0 || wb_wsel !== 5'd2) begin n_err++;
            $display("FAIL alu_latch got res=%h load=%h wsel=%0d exp 7 0 2", wb_result, wb_load, wb_wsel); end
        mem_en = 1'b0; outputi = 32'd9;
        cyc();
        n_cmp++; if (wb_result !== 32'd7 || mem_stall !== 1'b0) begin n_err++;
            $display("FAIL alu_hold got res=%h stall=%b exp 7 0", wb_result, mem_stall); end
        idle_inputs();
    endtask

    task automatic test_flush_idle();
        flush = 1'b1; dRENi = 1'b1; reg_wri = 1'b1; wseli = 5'd4; outputi = 32'h500;
        #1;
        n_cmp++; if (mem_stall !== 1'b0) begin n_err++; $display("FAIL flush_idle_stall got %b exp 0", mem_stall); end
        cyc();
        n_cmp++; if (dmemREN !== 1'b0 || wb_reg_wr !== 1'b0 || wb_wsel !== 5'd0) begin n_err++;
            $display("FAIL flush_idle_bubble got REN=%b wr=%b wsel=%0d exp 0 0 0", dmemREN, wb_reg_wr, wb_wsel); end
        idle_inputs();
    endtask

    task automatic test_reset_mid_access();
        dWENi = 1'b1; outputi = 32'h80;
        cyc();
        n_cmp++; if (dmemWEN !== 1'b1) begin n_err++; $display("FAIL mid_access_req got WEN=%b exp 1", dmemWEN); end
        RST = 1'b1;
        #1;
        n_cmp++; if (dmemWEN !== 1'b0 || mem_stall !== 1'b0) begin n_err++;
            $display("FAIL mid_access_rst got WEN=%b stall=%b exp 0 0", dmemWEN, mem_stall); end
        idle_inputs();
        cyc();
        RST = 1'b0;
        cyc();
    endtask

    task automatic test_halt();
        halti = 1'b1; dWENi = 1'b1; outputi = 32'h50; wdati = 32'hAA;
        cyc();
        n_cmp++; if (dmemWEN !== 1'b1 || wb_halt !== 1'b0) begin n_err++;
            $display("FAIL halt_store_req got WEN=%b halt=%b exp 1 0", dmemWEN, wb_halt); end
        dhit = 1'b1;
        cyc();
        n_cmp++; if (dmemWEN !== 1'b0 || wb_halt !== 1'b1 || wb_result !== 32'h50) begin n_err++;
            $display("FAIL halt_enter got WEN=%b halt=%b res=%h exp 0 1 50", dmemWEN, wb_halt, wb_result); end
        idle_inputs();
        dRENi = 1'b1; reg_wri = 1'b1; outputi = 32'h60;
        #1;
        n_cmp++; if (mem_stall !== 1'b0) begin n_err++; $display("FAIL halted_stall got %b exp 0", mem_stall); end
        cyc(); cyc();
        n_cmp++; if (dmemREN !== 1'b0 || wb_halt !== 1'b1 || wb_reg_wr !== 1'b0 || mem_stall !== 1'b0) begin n_err++;
            $display("FAIL halted_sticky got REN=%b halt=%b wr=%b stall=%b exp 0 1 0 0",
                     dmemREN, wb_halt, wb_reg_wr, mem_stall); end
        RST = 1'b1;
        #1;
        n_cmp++; if (wb_halt !== 1'b0) begin n_err++; $display("FAIL halt_reset got %b exp 0", wb_halt); end
        idle_inputs();
        cyc();
        RST = 1'b0;
        cyc();
    endtask

    initial begin
        test_reset();
        test_load();
        test_store_load();
        test_flush_access();
        test_alu();
        test_flush_idle();
        test_reset_mid_access();
        test_halt();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/mem_stage_ctrl.md
Name: mem_stage_ctrl

Overview:
- Consumer end of the execute/memory pipeline latch. It takes the latched execute results (ALU output, store data, read/write enables, register write-back control, halt) and runs the data-memory request/hit handshake toward the cache.
- It raises a pipeline stall while an access is outstanding, then loads the memory/write-back latch that feeds the write-back mux.
- It sits between the execute latch and the write-back stage in the 5-stage pipeline.

Parameters:
- WORD_W, 32, data/address width
- REG_AW, 5, register select width

Ports:
- CLK  in  1  clock; all state updates on rising edge
- RST  in  1  asynchronous, active-high reset
- mem_en  in  1  pipeline advance enable from hazard unit
- flush  in  1  squash: the instruction in this stage becomes a bubble
- outputi  in  WORD_W  ALU result; also the data address
- wdati  in  WORD_W  store data
- dRENi  in  1  load request from execute latch
- dWENi  in  1  store request from execute latch
- reg_wri  in  1  register-file write enable
- wseli  in  REG_AW  destination register
- write_sigi  in  1  write-back select (1 = memory data, 0 = ALU result)
- halti  in  1  halt instruction reached this stage
- dhit  in  1  cache completion for the current request
- dmemload  in  WORD_W  cache read data, valid with dhit
- dmemREN  out  1  registered load request to cache
- dmemWEN  out  1  registered store request to cache
- dmemaddr  out  WORD_W  registered request address
- dmemstore  out  WORD_W  registered store data
- mem_stall  out  1  combinational; holds all upstream stages
- wb_result  out  WORD_W  latched ALU result
- wb_load  out  WORD_W  latched load data
- wb_wsel  out  REG_AW  latched destination
- wb_reg_wr  out  1  latched write enable
- wb_write_sig  out  1  latched write-back select
- wb_halt  out  1  sticky halt to write-back/datapath

Behaviour:
- Reset (asynchronous, RST=1):
  - state=IDLE
  - all outputs 0; mem_stall=0 while RST=1
  - any outstanding request is abandoned
- Operation present: op = dRENi | dWENi.
  - If both are set, the access is a store: dmemREN=0, dmemWEN=1.
- State IDLE:
  - op=1, flush=0: mem_stall=1. Next state ACCESS. On the same edge, register the request: dmemaddr=outputi, dmemstore=wdati, dmemREN/dmemWEN per op.
  - op=0: mem_stall=0. On each edge with mem_en=1, the write-back latch loads wb_result=outputi, wb_load=0, wb_wsel, wb_reg_wr, wb_write_sig from the inputs.
  - flush=1 (with or without op): no request is issued and mem_stall=0. On the edge, the write-back latch loads a bubble: wb_reg_wr=0, wb_wsel=0, wb_write_sig=0.
- State ACCESS:
  - The request is held stable until dhit.
  - mem_stall = ~dhit.
  - On the dhit edge:
    - wb_load=dmemload (load) or 0 (store); wb_result=dmemaddr; the control fields load from the held inputs.
    - dmemREN/dmemWEN clear.
    - Next state IDLE.
  - Upstream advances on that same edge, so the operation is never reissued.
  - flush during ACCESS does not abort the access. It sets flush_pending. On dhit the write-back latch receives a bubble instead, and flush_pending clears.
  - mem_en is ignored while in ACCESS.
- Halt:
  - halti=1 in IDLE with flush=0: next state HALTED and wb_halt=1.
  - A halt that arrives with a memory op completes the access first, then enters HALTED.
- State HALTED:
  - Terminal until reset.
  - dmemREN=dmemWEN=0, mem_stall=0, wb_reg_wr=0, wb_halt=1.
- Latency:
  - Load with a dhit in the first ACCESS cycle: 2 cycles from op visible to write-back latch valid.
  - Each additional miss cycle adds 1.
- dhit in IDLE or HALTED is ignored.

Test Plan:
- Reset held with dRENi=1, outputi=0x100: all outputs 0, mem_stall=0. After release: dmemREN=1, dmemaddr=0x100 one cycle later.
- Load outputi=0x200, reg_wri=1, wseli=5, write_sigi=1; dhit 3 cycles after dmemREN with dmemload=0xDEADBEEF:
  - mem_stall is high for 4 cycles.
  - Then wb_load=0xDEADBEEF, wb_wsel=5, wb_reg_wr=1, dmemREN=0.
- Store and load requested together, wdati=0x1234, outputi=0x40: dmemWEN=1, dmemREN=0, dmemstore=0x1234. After dhit: wb_load=0.
- Flush asserted in ACCESS cycle 2 of a load: the request is held until dhit. The write-back latch then gets wb_reg_wr=0 and flush_pending clears.
- ALU op (dRENi=dWENi=0) with outputi=7, mem_en=1: mem_stall never asserts and wb_result=7 on the next edge. With mem_en=0 the latch holds its value.
- halti=1 with dWENi=1: the store completes on dhit, then wb_halt=1 sticky. Later dRENi=1 produces no dmemREN and keeps mem_stall=0. RST mid-ACCESS returns to IDLE with dmemWEN=0 immediately.
